// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: data/instruction master ports and the shared slave bus of the arbiter
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_data;
  logic              d_we;
  logic              d_start;
  logic [DATA_W-1:0] d_q;
  logic              d_done;
  logic              d_ready;
  logic [ADDR_W-1:0] i_addr;
  logic              i_start;
  logic [DATA_W-1:0] i_q;
  logic              i_done;
  logic              i_ready;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_data;
  logic              bus_we;
  logic              bus_start;
  logic [DATA_W-1:0] bus_q;
  logic              bus_done;
  logic              bus_ready;
  modport master (
    output d_addr, d_data, d_we, d_start, i_addr, i_start, bus_q, bus_done, bus_ready,
    input  d_q, d_done, d_ready, i_q, i_done, i_ready, bus_addr, bus_data, bus_we, bus_start
  );
  modport slave (
    input  d_addr, d_data, d_we, d_start, i_addr, i_start, bus_q, bus_done, bus_ready,
    output d_q, d_done, d_ready, i_q, i_done, i_ready, bus_addr, bus_data, bus_we, bus_start
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master (data over instruction) arbiter onto one memory bus slave
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic reset,
  mem_bus_arbiter_if.slave bif
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state;
  logic owner;
  logic d_pend, i_pend, d_nxt, i_nxt, d_cap, i_cap, d_fin, i_fin, busy;
  logic [ADDR_W-1:0] d_a, i_a;
  logic [DATA_W-1:0] d_w, d_last, i_last;
  logic d_wr;
  assign busy  = state != IDLE;
  assign d_fin = bif.bus_done && busy && !owner;
  assign i_fin = bif.bus_done && busy && owner;
  assign d_cap = bif.d_start && (!d_pend || d_fin);
  assign i_cap = bif.i_start && (!i_pend || i_fin);
  assign d_nxt = d_cap || (d_pend && !d_fin);
  assign i_nxt = i_cap || (i_pend && !i_fin);
  assign bif.d_done = d_fin;
  assign bif.i_done = i_fin;
  assign bif.d_q = d_fin ? bif.bus_q : d_last;
  assign bif.i_q = i_fin ? bif.bus_q : i_last;
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= 1'b0;
      d_pend        <= 1'b0;
      i_pend        <= 1'b0;
      d_a           <= '0;
      d_w           <= '0;
      d_wr          <= 1'b0;
      i_a           <= '0;
      d_last        <= '0;
      i_last        <= '0;
      bif.d_ready   <= 1'b0;
      bif.i_ready   <= 1'b0;
      bif.bus_start <= 1'b0;
      bif.bus_addr  <= '0;
      bif.bus_data  <= '0;
      bif.bus_we    <= 1'b0;
    end else begin
      d_pend      <= d_nxt;
      i_pend      <= i_nxt;
      bif.d_ready <= !d_nxt;
      bif.i_ready <= !i_nxt;
      if (d_cap) begin
        d_a  <= bif.d_addr;
        d_w  <= bif.d_data;
        d_wr <= bif.d_we;
      end
      if (i_cap) i_a <= bif.i_addr;
      if (d_fin) d_last <= bif.bus_q;
      if (i_fin) i_last <= bif.bus_q;
      bif.bus_start <= 1'b0;
      case (state)
        IDLE: if ((d_pend || i_pend) && bif.bus_ready) begin
          // instruction fetches are always reads with zero write data
          state         <= ISSUE;
          owner         <= !d_pend;
          bif.bus_start <= 1'b1;
          bif.bus_addr  <= d_pend ? d_a : i_a;
          bif.bus_data  <= d_pend ? d_w : '0;
          bif.bus_we    <= d_pend && d_wr;
        end
        ISSUE:   state <= bif.bus_done ? IDLE : WAIT;
        WAIT:    if (bif.bus_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized checks against a request-level model and slave memory
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mem_bus_arbiter_if bif();
  mem_bus_arbiter dut (.clk(clk), .reset(reset), .bif(bif));
  int checks = 0;
  int errors = 0;
  int n_ddone = 0;
  int slv_wait = 1;
  bit slv_rand = 1'b0;
  bit s_busy = 1'b0;
  int s_cnt = 0;
  logic [31:0] s_a, s_d;
  logic s_w;
  logic [31:0] smem [logic [31:0]];
  logic [31:0] rmem [logic [31:0]];
  bit mon_en = 1'b0;
  bit rst_prev = 1'b1;
  bit m_busy = 1'b0;
  bit exp_start = 1'b0;
  bit exp_own = 1'b0;
  bit m_cur = 1'b0;
  bit m_out [2];
  bit m_iss [2];
  logic [31:0] m_a [2];
  logic [31:0] m_d [2];
  logic m_w [2];
  logic [31:0] m_last [2];
  logic [31:0] e_ba = '0, e_bd = '0;
  logic e_bw = 1'b0;
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    bif.d_start = 1'b0;
    bif.i_start = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((m_out[0] || m_out[1] || s_busy) && n < 200) begin
      tick();
      n++;
    end
    chk("idle_timeout", 64'(n < 200), 64'd1);
  endtask
  task automatic wait_done(input bit inst, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      @(negedge clk);
      seen = inst ? bif.i_done : bif.d_done;
    end
  endtask
  // slave: completes each request after a chosen number of cycles, zero meaning in the start cycle
  initial begin
    bif.bus_done = 1'b0;
    bif.bus_q = '0;
    forever begin
      @(posedge clk);
      #2;
      bif.bus_done = 1'b0;
      bif.bus_q = $urandom;
      if (s_busy) s_cnt--;
      else if (bif.bus_start) begin
        s_busy = 1'b1;
        s_a = bif.bus_addr;
        s_d = bif.bus_data;
        s_w = bif.bus_we;
        s_cnt = slv_rand ? int'($urandom_range(0, 3)) : slv_wait;
      end
      if (s_busy && s_cnt == 0) begin
        bif.bus_done = 1'b1;
        bif.bus_q = s_w ? ~s_d : (smem.exists(s_a) ? smem[s_a] : dflt(s_a));
        if (s_w) smem[s_a] = s_d;
        s_busy = 1'b0;
      end
    end
  end
  // request-level model: per-master outstanding request, data priority, two-cycle issue latency
  initial begin
    bit was_busy, pend_d, pend_i, started;
    bit dn [2];
    logic [31:0] ret;
    for (int k = 0; k < 2; k++) begin
      m_out[k] = 0; m_iss[k] = 0; m_a[k] = '0; m_d[k] = '0; m_w[k] = 1'b0; m_last[k] = '0;
    end
    forever begin
      @(negedge clk);
      if (mon_en) begin
        was_busy = m_busy;
        started = exp_start;
        pend_d = m_out[0] && !m_iss[0];
        pend_i = m_out[1] && !m_iss[1];
        if (bif.d_done) n_ddone++;
        chk("bus_start", 64'(bif.bus_start), 64'(exp_start));
        if (exp_start) begin
          m_busy = 1'b1; m_cur = exp_own; m_iss[exp_own] = 1'b1;
          e_ba = m_a[exp_own]; e_bd = m_d[exp_own]; e_bw = m_w[exp_own];
        end
        chk("bus_addr", 64'(bif.bus_addr), 64'(e_ba));
        chk("bus_data", 64'(bif.bus_data), 64'(e_bd));
        chk("bus_we", 64'(bif.bus_we), 64'(e_bw));
        chk("d_ready", 64'(bif.d_ready), 64'(!rst_prev && !m_out[0]));
        chk("i_ready", 64'(bif.i_ready), 64'(!rst_prev && !m_out[1]));
        dn[0] = bif.bus_done && m_busy && !m_cur;
        dn[1] = bif.bus_done && m_busy && m_cur;
        chk("d_done", 64'(bif.d_done), 64'(dn[0]));
        chk("i_done", 64'(bif.i_done), 64'(dn[1]));
        ret = m_w[m_cur] ? ~m_d[m_cur] : (rmem.exists(m_a[m_cur]) ? rmem[m_a[m_cur]] : dflt(m_a[m_cur]));
        chk("d_q", 64'(bif.d_q), 64'(dn[0] ? ret : m_last[0]));
        chk("i_q", 64'(bif.i_q), 64'(dn[1] ? ret : m_last[1]));
        if (dn[0] || dn[1]) begin
          m_last[m_cur] = ret;
          if (m_w[m_cur]) rmem[m_a[m_cur]] = m_d[m_cur];
          m_busy = 1'b0;
          m_out[m_cur] = 1'b0;
        end
        if (bif.d_start && !m_out[0]) begin
          m_out[0] = 1'b1; m_iss[0] = 1'b0; m_a[0] = bif.d_addr; m_d[0] = bif.d_data; m_w[0] = bif.d_we;
        end
        if (bif.i_start && !m_out[1]) begin
          m_out[1] = 1'b1; m_iss[1] = 1'b0; m_a[1] = bif.i_addr; m_d[1] = '0; m_w[1] = 1'b0;
        end
        exp_start = !reset && !was_busy && !started && bif.bus_ready && (pend_d || pend_i);
        exp_own = !pend_d;
        if (reset) begin
          for (int k = 0; k < 2; k++) begin
            m_out[k] = 0; m_iss[k] = 0; m_last[k] = '0;
          end
          m_busy = 1'b0; exp_start = 1'b0; e_ba = '0; e_bd = '0; e_bw = 1'b0;
        end
        rst_prev = reset;
      end
    end
  end
  initial begin
    bit seen;
    int nd;
    bif.d_addr = '0; bif.d_data = '0; bif.d_we = 1'b0; bif.d_start = 1'b0;
    bif.i_addr = '0; bif.i_start = 1'b0; bif.bus_ready = 1'b1;
    smem[32'h100] = 32'hDEADBEEF; rmem[32'h100] = 32'hDEADBEEF;
    smem[32'h20] = 32'hCAFE0020; rmem[32'h20] = 32'hCAFE0020;
    reset = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_bus_start", 64'(bif.bus_start), 64'd0);
    chk("rst_d_ready", 64'(bif.d_ready), 64'd0);
    chk("rst_d_q", 64'(bif.d_q), 64'd0);
    // data read, three cycles from issue to done
    slv_wait = 3;
    tick();
    bif.d_addr = 32'h100; bif.d_we = 1'b0; bif.d_start = 1'b1;
    tick();
    @(negedge clk);
    chk("t1_no_start", 64'(bif.bus_start), 64'd0);
    tick();
    @(negedge clk);
    chk("t1_start", 64'(bif.bus_start), 64'd1);
    chk("t1_addr", 64'(bif.bus_addr), 64'h100);
    chk("t1_we", 64'(bif.bus_we), 64'd0);
    wait_done(1'b0, seen);
    chk("t1_done_seen", 64'(seen), 64'd1);
    chk("t1_dq", 64'(bif.d_q), 64'hDEADBEEF);
    tick();
    @(negedge clk);
    chk("t1_dq_hold", 64'(bif.d_q), 64'hDEADBEEF);
    wait_idle();
    // data write
    nd = n_ddone;
    tick();
    bif.d_addr = 32'h200; bif.d_data = 32'h12345678; bif.d_we = 1'b1; bif.d_start = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("t2_we", 64'(bif.bus_we), 64'd1);
    chk("t2_data", 64'(bif.bus_data), 64'h12345678);
    wait_idle();
    repeat (3) tick();
    chk("t2_one_done", 64'(n_ddone - nd), 64'd1);
    bif.d_we = 1'b0;
    // simultaneous requests, data wins
    slv_wait = 2;
    tick();
    bif.d_addr = 32'h10; bif.i_addr = 32'h20; bif.d_start = 1'b1; bif.i_start = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("t3_first_addr", 64'(bif.bus_addr), 64'h10);
    wait_done(1'b1, seen);
    chk("t3_i_done_seen", 64'(seen), 64'd1);
    chk("t3_iq", 64'(bif.i_q), 64'hCAFE0020);
    chk("t3_second_addr", 64'(bif.bus_addr), 64'h20);
    wait_idle();
    // zero-wait slave
    slv_wait = 0;
    tick();
    bif.d_addr = 32'h30; bif.i_addr = 32'h40; bif.d_start = 1'b1; bif.i_start = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("t4_d_done_issue", 64'(bif.d_done), 64'd1);
    tick();
    @(negedge clk);
    chk("t4_idle_gap", 64'(bif.bus_start), 64'd0);
    tick();
    @(negedge clk);
    chk("t4_next_start", 64'(bif.bus_start), 64'd1);
    chk("t4_next_addr", 64'(bif.bus_addr), 64'h40);
    chk("t4_i_done", 64'(bif.i_done), 64'd1);
    wait_idle();
    // slave not ready
    slv_wait = 1;
    bif.bus_ready = 1'b0;
    tick();
    bif.d_addr = 32'h50; bif.d_start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk);
      chk("t5_held", 64'(bif.bus_start), 64'd0);
    end
    tick();
    bif.bus_ready = 1'b1;
    @(negedge clk);
    chk("t5_ready_cycle", 64'(bif.bus_start), 64'd0);
    tick();
    @(negedge clk);
    chk("t5_start", 64'(bif.bus_start), 64'd1);
    tick();
    @(negedge clk);
    chk("t5_single_pulse", 64'(bif.bus_start), 64'd0);
    wait_idle();
    // dropped start while pending, and a new start in the done cycle
    slv_wait = 2;
    tick();
    bif.i_addr = 32'h60; bif.i_start = 1'b1;
    tick();
    bif.i_addr = 32'h64; bif.i_start = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_first_addr", 64'(bif.bus_addr), 64'h60);
    tick();
    tick();
    bif.i_addr = 32'h68; bif.i_start = 1'b1;
    @(negedge clk);
    chk("t6_done", 64'(bif.i_done), 64'd1);
    tick();
    @(negedge clk);
    chk("t6_relatched", 64'(bif.i_ready), 64'd0);
    tick();
    @(negedge clk);
    chk("t6_reissue", 64'(bif.bus_start), 64'd1);
    chk("t6_reissue_addr", 64'(bif.bus_addr), 64'h68);
    wait_idle();
    // reset while waiting on the slave
    tick();
    bif.d_addr = 32'h300; bif.d_start = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t7_no_d_done", 64'(bif.d_done), 64'd0);
    chk("t7_no_i_done", 64'(bif.i_done), 64'd0);
    chk("t7_bus_addr", 64'(bif.bus_addr), 64'd0);
    chk("t7_bus_data", 64'(bif.bus_data), 64'd0);
    chk("t7_d_q", 64'(bif.d_q), 64'd0);
    chk("t7_i_q", 64'(bif.i_q), 64'd0);
    tick();
    @(negedge clk);
    chk("t7_d_ready", 64'(bif.d_ready), 64'd1);
    chk("t7_i_ready", 64'(bif.i_ready), 64'd1);
    wait_idle();
    // random traffic over a small address window so reads observe earlier writes
    slv_rand = 1'b1;
    repeat (800) begin
      tick();
      bif.bus_ready = $urandom_range(0, 3) != 0;
      if (!m_out[0] && $urandom_range(0, 2) == 0) begin
        bif.d_addr = 32'($urandom_range(0, 15)) << 2;
        bif.d_data = $urandom;
        bif.d_we = 1'($urandom_range(0, 1));
        bif.d_start = 1'b1;
      end
      if (!m_out[1] && $urandom_range(0, 2) == 0) begin
        bif.i_addr = 32'($urandom_range(0, 15)) << 2;
        bif.i_start = 1'b1;
      end
    end
    bif.bus_ready = 1'b1;
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
